mem_bypass_history: RTL and testbench
=====================================

Name: mem_bypass_history

Overview:
- Memory-stage store-data bypass for the 5-stage pipeline, generalised for multicycle stalls.
- While the M-stage instruction is held (e.g. a mult/div stall or a memory wait), producer writes can commit in W and then leave the pipeline; those values must still be forwarded.
- The block keeps a small coalescing history of register writes committed since the M instruction was loaded.
- It forwards the newest matching value for the instruction's source register (the store-data register), or passes hold_data through.

Parameters:
- DATA_W, 32, width of register data.
- REG_W, 5, width of register index; register 0 is never forwarded.
- DEPTH, 4, number of history entries (distinct registers tracked), >=1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- m_load  in  1  a new instruction enters M this cycle; the history restarts.
- m_src_reg  in  REG_W  source register of the current M instruction (already decoded).
- m_src_used  in  1  the M instruction reads m_src_reg.
- hold_data  in  DATA_W  operand value latched into the X/M register.
- w_we  in  1  the W-stage instruction commits a register write this cycle.
- w_reg  in  REG_W  destination register of the W write.
- w_data  in  DATA_W  data of the W write.
- d  out  DATA_W  forwarded operand (combinational).
- fwd_hit  out  1  d comes from W or from the history, not from hold_data.
- fwd_src  out  2  0=hold_data, 1=live W, 2=history.
- ovf  out  1  sticky: a history entry was evicted since the last m_load.
- occ  out  $clog2(DEPTH+1)  number of valid history entries.

Behaviour:
- Reset (async, reset=0):
  - All entry valid bits cleared; ovf=0, occ=0.
  - d equals hold_data; fwd_hit=0, fwd_src=0.
  - Entry data is don't-care.
- Entries: {valid, reg, data, age}. Entry 0 is always the newest.
- Forward selection, all combinational, in priority order:
  - If m_src_used=0 or m_src_reg=0: d=hold_data, fwd_src=0.
  - Else if w_we and w_reg==m_src_reg: d=w_data, fwd_src=1.
  - Else if any valid entry matches m_src_reg: d=that entry's data, fwd_src=2. Coalescing guarantees at most one match.
  - Else: d=hold_data, fwd_src=0.
- Update on a clock edge, with w_commit = w_we && w_reg!=0:
  - m_load=1 and w_commit=0: all entries invalidated; ovf cleared.
  - m_load=1 and w_commit=1: history cleared, then the write becomes the sole entry; occ=1, ovf=0. The new instruction's hold_data was latched without this commit.
  - m_load=0 and w_commit=1, w_reg already in the history: that entry's data is updated in place and moved to newest. No shift beyond its slot; occ is unchanged.
  - m_load=0 and w_commit=1, w_reg new, history not full: entries shift toward older; the write is inserted as newest; occ+1.
  - m_load=0 and w_commit=1, w_reg new, history full: the oldest entry is dropped, the write is inserted, and ovf is set (sticky until the next m_load). occ stays DEPTH.
  - m_load=0 and w_commit=0: the history holds.
- Writes to register 0 never enter the history.
- Latency: forwarding is zero-cycle from w_* and from the history. A write becomes visible from the history on the cycle after it commits.
- If reset is asserted mid-stall, all forwarding state is lost immediately. d reverts to hold_data asynchronously.
- Synthesis assertion: DEPTH>=1. DEPTH=1 behaves as a single "last write" register.

Test Plan:
- Reset, then m_src_reg=5, m_src_used=1, hold_data=0x11 -> d=0x11, fwd_src=0, occ=0, ovf=0.
- Live W bypass: m_load pulse, then w_we=1, w_reg=5, w_data=0xAA -> d=0xAA, fwd_src=1 in the same cycle.
  - Next cycle with w_we=0 -> d=0xAA, fwd_src=2, occ=1.
- Coalescing: with M held, commit r5=0x1, then r7=0x2, then r5=0x3 -> occ=2, d(r5)=0x3, ovf=0.
- Overflow with DEPTH=4: commit r1..r5 distinct while M is held -> occ=4, ovf=1.
  - m_src_reg=1 -> d=hold_data (evicted).
  - m_src_reg=5 -> d=r5 data.
- Simultaneous m_load and w_we (r9=0x55), with prior history r3 present:
  - Next cycle occ=1, ovf=0.
  - m_src_reg=3 -> hold_data.
  - m_src_reg=9 -> 0x55.
- Register 0 and unused source:
  - w_reg=0 with w_we=1 -> occ unchanged, no forward.
  - m_src_used=0 with a matching entry -> d=hold_data.
  - Assert reset mid-stall -> occ=0 and fwd_hit=0 immediately.

Source files
------------

// File: rtl/mem_bypass_history.sv
// M-stage store-data bypass with a coalescing history of W commits made while M is held.
// Latency: forward is combinational from w_* and history; a commit is visible from history next cycle.
// Backpressure: none; the block follows m_load/w_we every cycle and never stalls the pipeline.
module mem_bypass_history #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       m_load,
  input  logic [REG_W-1:0]           m_src_reg,
  input  logic                       m_src_used,
  input  logic [DATA_W-1:0]          hold_data,
  input  logic                       w_we,
  input  logic [REG_W-1:0]           w_reg,
  input  logic [DATA_W-1:0]          w_data,
  output logic [DATA_W-1:0]          d,
  output logic                       fwd_hit,
  output logic [1:0]                 fwd_src,
  output logic                       ovf,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1) begin : g_depth_chk
      $error("mem_bypass_history: DEPTH must be >= 1");
    end
  endgenerate

  // Entry 0 is newest; valid entries are always packed from index 0 upward,
  // so slot position doubles as the entry's age.
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][REG_W-1:0]  reg_q, reg_d;
  logic [DEPTH-1:0][DATA_W-1:0] dat_q, dat_d;
  logic                         ovf_q, ovf_d;

  logic              w_commit;
  logic              hist_hit;
  logic [DATA_W-1:0] hist_dat;
  logic              w_in_hist;
  int                w_idx;
  logic [OCC_W-1:0]  occ_cnt;

  assign w_commit = w_we && (w_reg != '0);

  always_comb begin
    hist_hit  = 1'b0;
    hist_dat  = '0;
    w_in_hist = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (reg_q[i] == m_src_reg)) begin
        hist_hit = 1'b1;
        hist_dat = dat_q[i];
      end
      if (vld_q[i] && (reg_q[i] == w_reg)) begin
        w_in_hist = 1'b1;
        w_idx     = i;
      end
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + OCC_W'(vld_q[i]);
    end
  end

  always_comb begin
    d       = hold_data;
    fwd_src = 2'd0;
    if (m_src_used && (m_src_reg != '0)) begin
      if (w_we && (w_reg == m_src_reg)) begin
        d       = w_data;
        fwd_src = 2'd1;
      end else if (hist_hit) begin
        d       = hist_dat;
        fwd_src = 2'd2;
      end
    end
  end

  assign fwd_hit = (fwd_src != 2'd0);
  assign ovf     = ovf_q;
  assign occ     = occ_cnt;

  always_comb begin
    vld_d = vld_q;
    reg_d = reg_q;
    dat_d = dat_q;
    ovf_d = ovf_q;
    if (m_load) begin
      vld_d = '0;
      ovf_d = 1'b0;
      if (w_commit) begin
        vld_d[0] = 1'b1;
        reg_d[0] = w_reg;
        dat_d[0] = w_data;
      end
    end else if (w_commit) begin
      // A re-write only shifts the slots above its old position; a new
      // register shifts everything and pushes the oldest out.
      for (int i = 1; i < DEPTH; i++) begin
        if (!w_in_hist || (i <= w_idx)) begin
          vld_d[i] = vld_q[i-1];
          reg_d[i] = reg_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end
      vld_d[0] = 1'b1;
      reg_d[0] = w_reg;
      dat_d[0] = w_data;
      if (!w_in_hist && vld_q[DEPTH-1]) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      reg_q <= '0;
      dat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      reg_q <= reg_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mem_bypass_history.sv
// Bench for mem_bypass_history: directed scenarios then random traffic against a queue-based model.
module tb_mem_bypass_history;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              m_load = 1'b0;
  logic [REG_W-1:0]  m_src_reg = '0;
  logic              m_src_used = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;
  logic              w_we = 1'b0;
  logic [REG_W-1:0]  w_reg = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic [DATA_W-1:0] d;
  logic              fwd_hit;
  logic [1:0]        fwd_src;
  logic              ovf;
  logic [2:0]        occ;

  int n_cmp = 0;
  int n_err = 0;

  logic [REG_W-1:0]  mq_reg[$];
  logic [DATA_W-1:0] mq_dat[$];
  bit                m_ovf;

  mem_bypass_history #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .m_load(m_load), .m_src_reg(m_src_reg),
    .m_src_used(m_src_used), .hold_data(hold_data), .w_we(w_we), .w_reg(w_reg),
    .w_data(w_data), .d(d), .fwd_hit(fwd_hit), .fwd_src(fwd_src), .ovf(ovf), .occ(occ)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [DATA_W-1:0] ed;
    logic [1:0]        es;
    ed = hold_data;
    es = 2'd0;
    if (m_src_used && m_src_reg != 0) begin
      if (w_we && w_reg == m_src_reg) begin
        ed = w_data;
        es = 2'd1;
      end else begin
        for (int i = 0; i < mq_reg.size(); i++) begin
          if (mq_reg[i] == m_src_reg) begin
            ed = mq_dat[i];
            es = 2'd2;
          end
        end
      end
    end
    chk("d", 64'(d), 64'(ed));
    chk("fwd_src", 64'(fwd_src), 64'(es));
    chk("fwd_hit", 64'(fwd_hit), 64'(es != 2'd0));
    chk("occ", 64'(occ), 64'(mq_reg.size()));
    chk("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  task automatic model_update();
    bit commit;
    commit = w_we && (w_reg != 0);
    if (m_load) begin
      mq_reg.delete();
      mq_dat.delete();
      m_ovf = 1'b0;
      if (commit) begin
        mq_reg.push_front(w_reg);
        mq_dat.push_front(w_data);
      end
    end else if (commit) begin
      int found;
      found = -1;
      for (int i = 0; i < mq_reg.size(); i++) if (mq_reg[i] == w_reg) found = i;
      if (found >= 0) begin
        mq_reg.delete(found);
        mq_dat.delete(found);
      end else if (mq_reg.size() == DEPTH) begin
        void'(mq_reg.pop_back());
        void'(mq_dat.pop_back());
        m_ovf = 1'b1;
      end
      mq_reg.push_front(w_reg);
      mq_dat.push_front(w_data);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit ml, input logic [REG_W-1:0] src, input bit used,
                      input logic [DATA_W-1:0] hold, input bit we,
                      input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] wd);
    @(negedge clock);
    m_load = ml; m_src_reg = src; m_src_used = used; hold_data = hold;
    w_we = we; w_reg = wr; w_data = wd;
    #1;
    model_check();
    model_update();
  endtask

  initial begin
    m_ovf = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_hit", 64'(fwd_hit), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    step(0, 5, 1, 32'h11, 0, 0, 0);
    chk("idle_d", 64'(d), 64'h11);

    // Live W bypass, then the same value out of history.
    step(1, 5, 1, 32'h11, 0, 0, 0);
    step(0, 5, 1, 32'h11, 1, 5, 32'hAA);
    chk("live_d", 64'(d), 64'hAA);
    chk("live_src", 64'(fwd_src), 64'd1);
    step(0, 5, 1, 32'h11, 0, 0, 0);
    chk("hist_d", 64'(d), 64'hAA);
    chk("hist_src", 64'(fwd_src), 64'd2);
    chk("hist_occ", 64'(occ), 64'd1);

    // Coalescing.
    step(1, 5, 1, 32'h11, 0, 0, 0);
    step(0, 5, 1, 32'h11, 1, 5, 32'h1);
    step(0, 5, 1, 32'h11, 1, 7, 32'h2);
    step(0, 5, 1, 32'h11, 1, 5, 32'h3);
    step(0, 5, 1, 32'h11, 0, 0, 0);
    chk("coal_occ", 64'(occ), 64'd2);
    chk("coal_d", 64'(d), 64'h3);
    chk("coal_ovf", 64'(ovf), 64'd0);

    // Overflow: r1 is evicted, r5 survives.
    step(1, 1, 1, 32'h22, 0, 0, 0);
    for (int r = 1; r <= 5; r++) step(0, 1, 1, 32'h22, 1, REG_W'(r), 32'h100 + r);
    step(0, 1, 1, 32'h22, 0, 0, 0);
    chk("ovf_occ", 64'(occ), 64'd4);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_evict_d", 64'(d), 64'h22);
    step(0, 5, 1, 32'h22, 0, 0, 0);
    chk("ovf_keep_d", 64'(d), 64'h105);

    // m_load coinciding with a commit.
    step(1, 3, 1, 32'h44, 0, 0, 0);
    step(0, 3, 1, 32'h44, 1, 3, 32'h33);
    step(1, 3, 1, 32'h44, 1, 9, 32'h55);
    step(0, 3, 1, 32'h66, 0, 0, 0);
    chk("sim_occ", 64'(occ), 64'd1);
    chk("sim_ovf", 64'(ovf), 64'd0);
    chk("sim_r3_d", 64'(d), 64'h66);
    step(0, 9, 1, 32'h66, 0, 0, 0);
    chk("sim_r9_d", 64'(d), 64'h55);

    // Register 0 and unused source.
    step(0, 0, 1, 32'h66, 1, 0, 32'h77);
    chk("r0_hit", 64'(fwd_hit), 64'd0);
    step(0, 9, 1, 32'h66, 0, 0, 0);
    chk("r0_occ", 64'(occ), 64'd1);
    step(0, 9, 0, 32'h66, 0, 0, 0);
    chk("unused_d", 64'(d), 64'h66);

    // Reset mid-stall clears forwarding immediately.
    step(0, 9, 1, 32'h66, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_occ", 64'(occ), 64'd0);
    chk("mid_rst_hit", 64'(fwd_hit), 64'd0);
    chk("mid_rst_d", 64'(d), 64'h66);
    mq_reg.delete();
    mq_dat.delete();
    m_ovf = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Random traffic on a small register set to force hits, coalescing and eviction.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 7) == 0,
           REG_W'($urandom_range(0, 7)),
           $urandom_range(0, 7) != 0,
           $urandom,
           $urandom_range(0, 2) != 0,
           REG_W'($urandom_range(0, 7)),
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
